// File: rtl/fixed_pkg.sv
// fixed_pkg: shared fixed-point defaults, datapath state encoding and saturation limits
// used by both the signed multiplier and the mac_accumulator.
package fixed_pkg;

    localparam int N_DEF    = 32;
    localparam int FRAC_DEF = 20;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    function automatic logic [63:0] sat_max(input int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: combinational signed clamp from N+GUARD bits down to N bits with a sat flag.
module sat_clamp
    import fixed_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int GUARD = 8
) (
    input  logic [N+GUARD-1:0] din,
    output logic [N-1:0]       dout,
    output logic               sat
);

    localparam int W = N + GUARD;
    localparam logic [N-1:0] MAX_V = N'(sat_max(N));
    localparam logic [N-1:0] MIN_V = N'(sat_min(N));

    logic pos_ovf, neg_ovf;

    // The value fits in N bits only when all bits from N-1 upward match the sign bit.
    always_comb begin
        pos_ovf = !din[W-1] && (|din[W-2:N-1]);
        neg_ovf = din[W-1] && !(&din[W-2:N-1]);
        dout    = pos_ovf ? MAX_V : neg_ovf ? MIN_V : din[N-1:0];
        sat     = pos_ovf || neg_ovf;
    end

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums frames of LEN signed products in a guard-extended accumulator
// and emits one N-bit result per frame. Define MAC_SAT_EN for a saturating result.
module mac_accumulator
    import fixed_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int LEN   = 16,
    parameter int GUARD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat
);

    localparam int W  = N + GUARD;
    localparam int CW = $clog2(LEN + 1);

    if (LEN < 2 || LEN > 256 || GUARD < $clog2(LEN) || FRAC >= N) begin : g_bad_cfg
        $error("mac_accumulator: illegal LEN/GUARD/FRAC combination");
    end

    state_t         state, state_n;
    logic [W-1:0]   acc, acc_n, ext, sum;
    logic [CW-1:0]  cnt, cnt_n;
    logic [N-1:0]   res, od_n;
    logic           res_sat, os_n, ov_n, take;

    assign in_ready = state != OUT;
    assign take     = in_valid && in_ready;
    assign ext      = {{GUARD{in_data[N-1]}}, in_data};
    // The first beat of a frame loads rather than adds, so IDLE needs no acc clear.
    assign sum      = (state == ACC ? acc : '0) + ext;

`ifdef MAC_SAT_EN
    sat_clamp #(.N(N), .GUARD(GUARD)) u_clamp (
        .din  (sum),
        .dout (res),
        .sat  (res_sat)
    );
`else
    assign res     = sum[N-1:0];
    assign res_sat = 1'b0;
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        od_n    = out_data;
        os_n    = out_sat;
        ov_n    = out_valid;
        if (clear) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ov_n    = 1'b0;
        end else if (state == OUT) begin
            if (out_ready) begin
                state_n = IDLE;
                cnt_n   = '0;
                ov_n    = 1'b0;
            end
        end else if (take) begin
            acc_n   = sum;
            cnt_n   = cnt + 1'b1;
            state_n = ACC;
            if (cnt == CW'(LEN - 1)) begin
                state_n = OUT;
                od_n    = res;
                os_n    = res_sat;
                ov_n    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            out_data  <= od_n;
            out_sat   <= os_n;
            out_valid <= ov_n;
        end
    end

endmodule
